// File: rtl/id_digit_sequencer_pkg.sv
// Shared definitions for the digit sequencer.
// Holds the run-mode encodings, the ping-pong direction type and a helper
// that sizes counters and indices so they are never zero bits wide.
// No ports; imported by id_digit_sequencer and step_prescaler.
package id_seq_pkg;

   localparam logic [1:0] MODE_FWD     = 2'b00;
   localparam logic [1:0] MODE_REV     = 2'b01;
   localparam logic [1:0] MODE_PING    = 2'b10;
   localparam logic [1:0] MODE_ONESHOT = 2'b11;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Width needed to hold values 0..n-1, but at least one bit so that a
   // single-digit sequence or a divide-by-one prescaler still gets a real
   // register instead of a zero-width vector.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/id_digit_sequencer_prescaler.sv
// step_prescaler: turns a run enable into a one-cycle step strobe every DIV
// enabled cycles.
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  synchronous active-low reset, clears the count
//   en_i     count enable (already qualified by hold at the top level)
//   clr_i    synchronous clear back to count zero, no strobe in that cycle
//   step_o   high in the cycle whose edge should take a step
module step_prescaler
   import id_seq_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   input  logic clr_i,
   output logic step_o
);

   localparam int CNT_W = clog2_min1(DIV);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;

   // The count runs 0..DIV-1 and wraps; it simply parks when not enabled so
   // a paused sequence resumes with the same phase it had.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = (count_q == LAST_CNT) ? '0 : count_q + ONE_CNT;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // A clear wins over a pending strobe so a restart never doubles as a step.
   assign step_o = en_i & ~clr_i & (count_q == LAST_CNT);

endmodule

// File: rtl/id_digit_sequencer.sv
// id_digit_sequencer: steps through a packed sequence of NUM_DIGITS digits at
// a rate of one step per DIV enabled cycles, in loop-forward, loop-reverse,
// ping-pong or one-shot order. Digit 0 is the most significant field of SEQ.
// Ports:
//   clk_i      system clock, rising edge
//   reset_i    synchronous active-low reset
//   en_i       run enable
//   hold_i     freezes prescaler and index (overrides en_i)
//   restart_i  return to the start position of the selected mode
//   mode_i     00 loop-fwd, 01 loop-rev, 10 ping-pong, 11 one-shot-fwd
//   hex_o      digit currently selected by idx_o
//   idx_o      current digit index, always < NUM_DIGITS
//   tick_o     one-cycle pulse after each step
//   wrap_o     one-cycle pulse with tick_o when a step lands on a pass endpoint
//   done_o     one-shot pass complete (level)
module id_digit_sequencer
   import id_seq_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int DIGIT_W = 4,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0] SEQ = 32'h9108_5632,
   parameter int DIV = 1
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic                               en_i,
   input  logic                               hold_i,
   input  logic                               restart_i,
   input  logic [1:0]                         mode_i,
   output logic [DIGIT_W-1:0]                 hex_o,
   output logic [clog2_min1(NUM_DIGITS)-1:0]  idx_o,
   output logic                               tick_o,
   output logic                               wrap_o,
   output logic                               done_o
);

   localparam int IDX_W = clog2_min1(NUM_DIGITS);
   localparam int SEQ_W = NUM_DIGITS * DIGIT_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   logic [IDX_W-1:0] idx_q, idx_d, idxInc, idxDec;
   dir_e             dir_q, dir_d, pingDir;
   logic             done_q, done_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             prescaleStep, step;
   logic [SEQ_W-1:0] seqShifted;

   step_prescaler #(
      .DIV(DIV)
   ) uPrescaler (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en_i & ~hold_i),
      .clr_i   (restart_i),
      .step_o  (prescaleStep)
   );

   // A finished one-shot pass blocks stepping until done is cleared, either
   // by restart or by leaving one-shot mode.
   assign step = prescaleStep & ~done_q;

   // Next-state logic for index, direction and done. The wrap-around helpers
   // compare against the last index explicitly so that non-power-of-two
   // lengths never produce an index outside 0..NUM_DIGITS-1.
   always_comb begin
      idxInc  = (idx_q == LAST_IDX) ? '0 : idx_q + ONE_IDX;
      idxDec  = (idx_q == '0) ? LAST_IDX : idx_q - ONE_IDX;
      idx_d   = idx_q;
      dir_d   = dir_q;
      pingDir = dir_q;
      done_d  = done_q && (mode_i == MODE_ONESHOT);
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (restart_i) begin
         idx_d  = (mode_i == MODE_REV) ? LAST_IDX : '0;
         dir_d  = DIR_UP;
         done_d = 1'b0;
      end else if (step) begin
         tick_d = 1'b1;
         case (mode_i)
            MODE_FWD: begin
               idx_d  = idxInc;
               wrap_d = (idx_q == LAST_IDX);
            end
            MODE_REV: begin
               idx_d  = idxDec;
               wrap_d = (idx_q == '0);
            end
            MODE_PING: begin
               if (idx_q == '0) begin
                  pingDir = DIR_UP;
               end else if (idx_q == LAST_IDX) begin
                  pingDir = DIR_DOWN;
               end
               idx_d  = (pingDir == DIR_UP) ? idxInc : idxDec;
               wrap_d = (idx_d == LAST_IDX) || (idx_d == '0);
               if (idx_d == LAST_IDX) begin
                  dir_d = DIR_DOWN;
               end else if (idx_d == '0) begin
                  dir_d = DIR_UP;
               end else begin
                  dir_d = pingDir;
               end
            end
            default: begin
               idx_d = idxInc;
               if (idxInc == LAST_IDX) begin
                  wrap_d = 1'b1;
                  done_d = 1'b1;
               end
            end
         endcase
      end
   end

   // State register with synchronous active-low reset to the power-on state.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         idx_q  <= '0;
         dir_q  <= DIR_UP;
         done_q <= 1'b0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         dir_q  <= dir_d;
         done_q <= done_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
      end
   end

   // Outputs: the digit is selected straight from the registered index so
   // hex and idx always change together.
   always_comb begin
      seqShifted = SEQ >> ((NUM_DIGITS - 1 - int'(idx_q)) * DIGIT_W);
      hex_o      = seqShifted[DIGIT_W-1:0];
      idx_o      = idx_q;
      tick_o     = tick_q;
      wrap_o     = wrap_q;
      done_o     = done_q;
   end

endmodule

// File: tb/tb_id_digit_sequencer.sv
// Testbench for id_digit_sequencer. Six instances with different lengths and
// prescalers share one set of inputs; a behavioural model of every instance
// is compared each cycle, alongside directed vectors and sequences.
module tb_id_digit_sequencer;

   localparam int NINST = 6;

   logic       clk = 1'b0;
   logic       resetN, en, hold, restart;
   logic [1:0] mode, curMode;

   always #5 clk = ~clk;

   logic [3:0]       hex0, hex1, hex2, hex3, hex4, hex5;
   logic [2:0]       idx0, idx1, idx3, idx5;
   logic [1:0]       idx2;
   logic [0:0]       idx4;
   logic [NINST-1:0] tickV, wrapV, doneV;

   id_digit_sequencer #(.NUM_DIGITS(8), .DIGIT_W(4), .SEQ(32'h9108_5632), .DIV(1)) u0 (
      .clk_i(clk), .reset_i(resetN), .en_i(en), .hold_i(hold), .restart_i(restart), .mode_i(mode),
      .hex_o(hex0), .idx_o(idx0), .tick_o(tickV[0]), .wrap_o(wrapV[0]), .done_o(doneV[0]));
   id_digit_sequencer #(.NUM_DIGITS(8), .DIGIT_W(4), .SEQ(32'h9108_5632), .DIV(3)) u1 (
      .clk_i(clk), .reset_i(resetN), .en_i(en), .hold_i(hold), .restart_i(restart), .mode_i(mode),
      .hex_o(hex1), .idx_o(idx1), .tick_o(tickV[1]), .wrap_o(wrapV[1]), .done_o(doneV[1]));
   id_digit_sequencer #(.NUM_DIGITS(4), .DIGIT_W(4), .SEQ(16'h1234), .DIV(1)) u2 (
      .clk_i(clk), .reset_i(resetN), .en_i(en), .hold_i(hold), .restart_i(restart), .mode_i(mode),
      .hex_o(hex2), .idx_o(idx2), .tick_o(tickV[2]), .wrap_o(wrapV[2]), .done_o(doneV[2]));
   id_digit_sequencer #(.NUM_DIGITS(5), .DIGIT_W(4), .SEQ(20'h13579), .DIV(1)) u3 (
      .clk_i(clk), .reset_i(resetN), .en_i(en), .hold_i(hold), .restart_i(restart), .mode_i(mode),
      .hex_o(hex3), .idx_o(idx3), .tick_o(tickV[3]), .wrap_o(wrapV[3]), .done_o(doneV[3]));
   id_digit_sequencer #(.NUM_DIGITS(1), .DIGIT_W(4), .SEQ(4'hC), .DIV(1)) u4 (
      .clk_i(clk), .reset_i(resetN), .en_i(en), .hold_i(hold), .restart_i(restart), .mode_i(mode),
      .hex_o(hex4), .idx_o(idx4), .tick_o(tickV[4]), .wrap_o(wrapV[4]), .done_o(doneV[4]));
   id_digit_sequencer #(.NUM_DIGITS(8), .DIGIT_W(4), .SEQ(32'h9108_5632), .DIV(4)) u5 (
      .clk_i(clk), .reset_i(resetN), .en_i(en), .hold_i(hold), .restart_i(restart), .mode_i(mode),
      .hex_o(hex5), .idx_o(idx5), .tick_o(tickV[5]), .wrap_o(wrapV[5]), .done_o(doneV[5]));

   int dHex[NINST];
   int dIdx[NINST];

   // Gather the differently sized instance outputs into plain integer arrays.
   always_comb begin
      dHex[0] = int'(hex0);
      dHex[1] = int'(hex1);
      dHex[2] = int'(hex2);
      dHex[3] = int'(hex3);
      dHex[4] = int'(hex4);
      dHex[5] = int'(hex5);
      dIdx[0] = int'(idx0);
      dIdx[1] = int'(idx1);
      dIdx[2] = int'(idx2);
      dIdx[3] = int'(idx3);
      dIdx[4] = int'(idx4);
      dIdx[5] = int'(idx5);
   end

   // Instance configurations and their digit lists, read left to right.
   int cfgN[NINST]   = '{8, 8, 4, 5, 1, 8};
   int cfgDiv[NINST] = '{1, 3, 1, 1, 1, 4};
   int digits[NINST][8] = '{
      '{9, 1, 0, 8, 5, 6, 3, 2},
      '{9, 1, 0, 8, 5, 6, 3, 2},
      '{1, 2, 3, 4, 0, 0, 0, 0},
      '{1, 3, 5, 7, 9, 0, 0, 0},
      '{12, 0, 0, 0, 0, 0, 0, 0},
      '{9, 1, 0, 8, 5, 6, 3, 2}
   };

   int mIdx[NINST];
   int mPre[NINST];
   bit mUp[NINST];
   bit mDone[NINST];
   bit mTick[NINST];
   bit mWrap[NINST];

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      bit         en;
      bit         hold;
      bit         restart;
      logic [1:0] mode;
      int         expHex;
      int         expIdx;
      bit         expTick;
      bit         expWrap;
   } vec_t;

   vec_t vecs[13];

   // Reference model: advances every instance by one clock edge using the
   // sequencing rules with plain modular arithmetic on the digit position.
   task automatic modelEdge();
      for (int k = 0; k < NINST; k++) begin
         int n;
         int d;
         int nxt;
         bit goUp;
         bit stepNow;
         n = cfgN[k];
         d = cfgDiv[k];
         if (!resetN) begin
            mIdx[k] = 0; mPre[k] = 0; mUp[k] = 1'b1;
            mDone[k] = 1'b0; mTick[k] = 1'b0; mWrap[k] = 1'b0;
         end else if (restart) begin
            mIdx[k] = (mode == 2'b01) ? n - 1 : 0;
            mPre[k] = 0; mUp[k] = 1'b1;
            mDone[k] = 1'b0; mTick[k] = 1'b0; mWrap[k] = 1'b0;
         end else begin
            mTick[k] = 1'b0;
            mWrap[k] = 1'b0;
            stepNow = en && !hold && (mPre[k] == d - 1) && !mDone[k];
            if (mode != 2'b11) mDone[k] = 1'b0;
            if (en && !hold) mPre[k] = (mPre[k] + 1) % d;
            if (stepNow) begin
               mTick[k] = 1'b1;
               case (mode)
                  2'b00: begin
                     mWrap[k] = (mIdx[k] == n - 1);
                     mIdx[k] = (mIdx[k] + 1) % n;
                  end
                  2'b01: begin
                     mWrap[k] = (mIdx[k] == 0);
                     mIdx[k] = (mIdx[k] + n - 1) % n;
                  end
                  2'b10: begin
                     goUp = mUp[k];
                     if (mIdx[k] == 0) goUp = 1'b1;
                     else if (mIdx[k] == n - 1) goUp = 1'b0;
                     nxt = goUp ? (mIdx[k] + 1) % n : (mIdx[k] + n - 1) % n;
                     mWrap[k] = (nxt == 0) || (nxt == n - 1);
                     if (nxt == n - 1) mUp[k] = 1'b0;
                     else if (nxt == 0) mUp[k] = 1'b1;
                     else mUp[k] = goUp;
                     mIdx[k] = nxt;
                  end
                  default: begin
                     nxt = (mIdx[k] + 1) % n;
                     if (nxt == n - 1) begin
                        mWrap[k] = 1'b1;
                        mDone[k] = 1'b1;
                     end
                     mIdx[k] = nxt;
                  end
               endcase
            end
         end
      end
   endtask

   // Single comparison: counts it and reports a mismatch with both values.
   task automatic checkOutput(input string name, input int k, input int act, input int exp);
      checkCount++;
      if (act == exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s inst%0d at %0t: got %0d, expected %0d", name, k, $time, act, exp);
      end
   endtask

   // Compare every instance against the reference model.
   task automatic checkModelAll();
      for (int k = 0; k < NINST; k++) begin
         checkOutput("model_hex", k, dHex[k], digits[k][mIdx[k]]);
         checkOutput("model_idx", k, dIdx[k], mIdx[k]);
         checkOutput("model_tick", k, int'(tickV[k]), int'(mTick[k]));
         checkOutput("model_wrap", k, int'(wrapV[k]), int'(mWrap[k]));
         checkOutput("model_done", k, int'(doneV[k]), int'(mDone[k]));
      end
   endtask

   // Drive one cycle of inputs, clock it, then check all instances 1ns later.
   task automatic applyStimulus(input bit rstN, input bit enV, input bit holdV,
                                input bit restartV, input logic [1:0] modeV);
      resetN  = rstN;
      en      = enV;
      hold    = holdV;
      restart = restartV;
      mode    = modeV;
      modelEdge();
      @(posedge clk);
      #1;
      checkModelAll();
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1, 1, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 0, 2, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 8, 3, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b00, 5, 4, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b00, 6, 5, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b00, 3, 6, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b00, 2, 7, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b00, 9, 0, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 9, 0, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b00, 9, 0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b01, 2, 7, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b01, 3, 6, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b01, 6, 5, 1'b1, 1'b0};

      for (int k = 0; k < NINST; k++) begin
         mIdx[k] = 0; mPre[k] = 0; mUp[k] = 1'b1;
         mDone[k] = 1'b0; mTick[k] = 1'b0; mWrap[k] = 1'b0;
      end
      resetN = 1'b0; en = 1'b0; hold = 1'b0; restart = 1'b0; mode = 2'b00;
      curMode = 2'b00;

      // Reset state.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      checkOutput("rst_hex", 0, dHex[0], 9);
      checkOutput("rst_idx", 0, dIdx[0], 0);
      checkOutput("rst_tick", 0, int'(tickV[0]), 0);
      checkOutput("rst_wrap", 0, int'(wrapV[0]), 0);
      checkOutput("rst_done", 0, int'(doneV[0]), 0);

      // Loop-forward walk, pause, hold and a reverse restart on instance 0.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, vecs[i].en, vecs[i].hold, vecs[i].restart, vecs[i].mode);
         checkOutput("vec_hex", i, dHex[0], vecs[i].expHex);
         checkOutput("vec_idx", i, dIdx[0], vecs[i].expIdx);
         checkOutput("vec_tick", i, int'(tickV[0]), int'(vecs[i].expTick));
         checkOutput("vec_wrap", i, int'(wrapV[0]), int'(vecs[i].expWrap));
      end

      // Divide-by-three reverse run with a wrap and a five-cycle hold.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b01);
      checkOutput("div3_start", 1, dIdx[1], 7);
      for (int c = 1; c <= 24; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
         checkOutput("div3_idx", 1, dIdx[1], (7 - c / 3 + 8) % 8);
         checkOutput("div3_tick", 1, int'(tickV[1]), int'(c % 3 == 0));
         checkOutput("div3_wrap", 1, int'(wrapV[1]), int'(c == 24));
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
         checkOutput("hold_idx", 1, dIdx[1], 7);
         checkOutput("hold_tick", 1, int'(tickV[1]), 0);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
      checkOutput("after_hold_idx", 1, dIdx[1], 7);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b01);
      checkOutput("after_hold_step", 1, dIdx[1], 6);
      checkOutput("after_hold_tick", 1, int'(tickV[1]), 1);

      // Ping-pong on the four-digit instance.
      begin
         int pingHex[7]  = '{2, 3, 4, 3, 2, 1, 2};
         int pingWrap[7] = '{0, 0, 1, 0, 0, 1, 0};
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b10);
         checkOutput("ping_start", 2, dHex[2], 1);
         for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
            checkOutput("ping_hex", 2, dHex[2], pingHex[c]);
            checkOutput("ping_wrap", 2, int'(wrapV[2]), pingWrap[c]);
         end
      end

      // One-shot: completes at idx 7, parks, and restarts cleanly.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b11);
      for (int c = 1; c <= 7; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
         checkOutput("os_idx", 0, dIdx[0], c);
         checkOutput("os_done", 0, int'(doneV[0]), int'(c == 7));
         checkOutput("os_wrap", 0, int'(wrapV[0]), int'(c == 7));
      end
      checkOutput("os_hex", 0, dHex[0], 2);
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
         checkOutput("os_park_idx", 0, dIdx[0], 7);
         checkOutput("os_park_tick", 0, int'(tickV[0]), 0);
         checkOutput("os_park_done", 0, int'(doneV[0]), 1);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
      checkOutput("os_restart_idx", 0, dIdx[0], 0);
      checkOutput("os_restart_done", 0, int'(doneV[0]), 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
      checkOutput("os_resume_idx", 0, dIdx[0], 1);
      checkOutput("os_resume_tick", 0, int'(tickV[0]), 1);

      // Five-digit and single-digit sequences in loop-forward.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      for (int c = 1; c <= 12; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
         checkOutput("n5_idx", 3, dIdx[3], c % 5);
         checkOutput("n5_wrap", 3, int'(wrapV[3]), int'(c % 5 == 0));
         checkOutput("n1_hex", 4, dHex[4], 12);
         checkOutput("n1_wrap", 4, int'(wrapV[4]), 1);
      end

      // Reset in the middle of a divide-by-four run at idx 5, prescaler 2.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
      for (int c = 1; c <= 22; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
      end
      checkOutput("div4_pre_idx", 5, dIdx[5], 5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      checkOutput("midrst_idx", 5, dIdx[5], 0);
      checkOutput("midrst_tick", 5, int'(tickV[5]), 0);
      checkOutput("midrst_wrap", 5, int'(wrapV[5]), 0);
      checkOutput("midrst_done", 5, int'(doneV[5]), 0);
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
         checkOutput("postrst_idx", 5, dIdx[5], (c == 4) ? 1 : 0);
         checkOutput("postrst_tick", 5, int'(tickV[5]), int'(c == 4));
      end
      checkOutput("pre_restart_idx", 0, dIdx[0], 4);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
      checkOutput("restart_step_idx", 0, dIdx[0], 0);
      checkOutput("restart_step_tick", 0, int'(tickV[0]), 0);

      // Randomized run checked against the model only.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(19, 0) == 0) curMode = 2'($urandom_range(3, 0));
         applyStimulus($urandom_range(63, 0) != 0, $urandom_range(3, 0) != 0,
                       $urandom_range(7, 0) == 0, $urandom_range(31, 0) == 0, curMode);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
